past_sequence_sum_collector: RTL and testbench

//   Downstream stage of the past-sequence adder. Re-times a sample-valid strobe through the

---
 rtl/past_sequence_sum_collector.sv | 97 +++++++++
 tb/tb_past_sequence_sum_collector.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/past_sequence_sum_collector.sv
// Re-times the adder sample strobe, drops warmup sums and
// queues valid sums in a small FIFO with valid/ready output.
module past_sequence_sum_collector #(
  parameter int N          = 4,
  parameter int DW         = 8,
  parameter int ADDER_REGS = 4,
  parameter int WARMUP     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [DW-1:0]               sum_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DW-1:0]               out_data,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic [15:0]                 drop_count
);

  localparam int LAT = N * ADDER_REGS;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int WW  = $clog2(WARMUP + 2);

  logic [LAT-1:0] dly_q, dly_d;
  logic [WW-1:0]  wu_q, wu_d;
  logic [DW-1:0]  mem_q [FIFO_DEPTH];
  logic [DW-1:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           ovf_q, ovf_d;
  logic [15:0]    drop_q, drop_d;

  logic dv, warm, push, full, pop, wr, lost;

  always_comb begin
    dly_d[0] = in_valid;
    for (int i = 1; i < LAT; i++) begin
      dly_d[i] = dly_q[i-1];
    end
    dv   = dly_q[LAT-1];
    warm = (wu_q == WW'(WARMUP));
    push = dv && warm;
    wu_d = (dv && !warm) ? wu_q + WW'(1) : wu_q;

    full = (level_q == LW'(FIFO_DEPTH));
    pop  = (level_q != '0) && out_ready;
    // A full FIFO still accepts a push when the head leaves this cycle
    wr   = push && (!full || pop);
    lost = push && full && !pop;

    mem_d = mem_q;
    if (wr) begin
      mem_d[wr_ptr_q] = sum_in;
    end
    wr_ptr_d = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(wr) - LW'(pop);

    ovf_d  = ovf_q | lost;
    drop_d = (lost && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q    <= '0;
      wu_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      dly_q    <= dly_d;
      wu_q     <= wu_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      mem_q    <= mem_d;
    end
  end

  assign out_valid  = (level_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign level      = level_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_past_sequence_sum_collector.sv
// Directed and random checks of the sum collector against
// a cycle-indexed history model with a queue FIFO.
module tb_past_sequence_sum_collector;

  localparam int N = 4, DW = 8, AR = 4, WARMUP = 32, DEPTH = 8;
  localparam int LAT = N * AR;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] sum_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [3:0]    level;
  logic          overflow;
  logic [15:0]   drop_count;

  past_sequence_sum_collector #(
    .N(N), .DW(DW), .ADDER_REGS(AR),
    .WARMUP(WARMUP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .sum_in(sum_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // model state
  bit          vhist[$];
  logic [DW-1:0] shist[$];
  logic [DW-1:0] q[$];
  logic [DW-1:0] plog[$];
  int cyc = 0;
  int rst_cyc = -1;
  int wu = 0;
  bit m_ovf = 0;
  int m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit dv, pop;
    vhist.push_back(in_valid);
    shist.push_back(sum_in);
    if (rst) begin
      q.delete();
      wu = 0; m_ovf = 0; m_drop = 0;
      rst_cyc = cyc;
    end else begin
      pop = (q.size() > 0) && out_ready;
      dv  = (cyc - LAT > rst_cyc) && vhist[cyc-LAT];
      if (pop) plog.push_back(q.pop_front());
      if (dv) begin
        if (wu < WARMUP) wu++;
        else if (q.size() < DEPTH) q.push_back(sum_in);
        else begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
    end
  endtask

  task automatic compare();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("level", 32'(level), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
    if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    cyc++;
  endtask

  task automatic drive(input bit v, input bit r, input bit rs);
    in_valid  = v;
    out_ready = r;
    rst       = rs;
    sum_in    = DW'($urandom);
  endtask

  int base, first_seen, drop0;
  bit seen;

  initial begin
    drive(0, 0, 1);
    @(negedge clk);

    // 1: reset with random inputs
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 1'($urandom), 1);
      tick();
    end
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_out_data", 32'(out_data), 0);

    // 2: latency and warmup, continuous valid
    base = cyc;
    first_seen = -1;
    for (int i = 0; i < 80; i++) begin
      drive(1, 1, 0);
      tick();
      if (first_seen < 0 && out_valid) first_seen = cyc - 1 - base + 1;
    end
    chk("first_out_valid_cycle", 32'(first_seen), LAT + WARMUP + 1);
    for (int i = 0; i < 30; i++) begin
      drive(0, 1, 0);
      tick();
    end

    // 3: sparse valid after warmup
    plog.delete();
    base = cyc;
    for (int k = 0; k < 70; k++) begin
      drive(k == 40 || k == 41 || k == 45, 1, 0);
      tick();
    end
    chk("sparse_pops", 32'(plog.size()), 3);
    if (plog.size() == 3) begin
      chk("sparse_d0", 32'(plog[0]), 32'(shist[base+56]));
      chk("sparse_d1", 32'(plog[1]), 32'(shist[base+57]));
      chk("sparse_d2", 32'(plog[2]), 32'(shist[base+61]));
    end

    // 4: backpressure, 10 pushes into depth 8
    base = cyc;
    for (int k = 0; k < 40; k++) begin
      drive(k < 10, 0, 0);
      tick();
    end
    chk("bp_level", 32'(level), 8);
    chk("bp_overflow", 32'(overflow), 1);
    chk("bp_drop", 32'(drop_count), 2);
    plog.delete();
    for (int k = 0; k < 12; k++) begin
      drive(0, 1, 0);
      tick();
    end
    chk("bp_drained", 32'(plog.size()), 8);
    if (plog.size() == 8)
      for (int i = 0; i < 8; i++)
        chk("bp_order", 32'(plog[i]), 32'(shist[base+16+i]));

    // 5: full with simultaneous push and pop
    base = cyc;
    for (int k = 0; k < 30; k++) begin
      drive(1, 0, 0);
      tick();
    end
    chk("full_level", 32'(level), 8);
    drop0 = int'(drop_count);
    plog.delete();
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 0);
      tick();
      chk("simul_level", 32'(level), 8);
    end
    chk("simul_drop", 32'(drop_count), 32'(drop0));
    if (plog.size() > 0) chk("simul_head", 32'(plog[0]), 32'(shist[base+16]));
    for (int k = 0; k < 40; k++) begin
      drive(0, 1, 0);
      tick();
    end

    // 6: mid-run reset with 5 queued and 16 in flight
    for (int k = 0; k < 21; k++) begin
      drive(1, 0, 0);
      tick();
    end
    chk("pre_rst_level", 32'(level), 5);
    drive(1'($urandom), 1'($urandom), 1);
    tick();
    seen = 0;
    for (int k = 0; k < LAT + WARMUP; k++) begin
      drive(1, 1, 0);
      tick();
      if (out_valid) seen = 1;
    end
    chk("mid_rst_no_output", 32'(seen), 0);
    chk("mid_rst_drop", 32'(drop_count), 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 0);
      tick();
    end
    chk("mid_rst_resume", 32'(out_valid), 1);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6, 0);
      tick();
    end
    for (int k = 0; k < 40; k++) begin
      drive(0, 1, 0);
      tick();
    end
    chk("final_empty", 32'(level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
